pio_debounce_capture: RTL
=========================

PIO_DEBOUNCE_CAPTURE -- requirements
Module: pio_debounce_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 18: number of input channels, legal range 1..32.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 50000: stable cycles required before a channel's debounced value changes, legal range 1..2^20.
REQ-003 SHALL have parameter INVERT_MASK, default 0: per-bit mask, WIDTH bits; a 1 inverts that raw input so active-low keys read as 1 when pressed.
REQ-004 SHALL have port clk_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset_reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port in_export, input, WIDTH bits: raw asynchronous switch or key inputs.
REQ-007 SHALL have port address, input, 2 bits: Avalon-MM slave word address.
REQ-008 SHALL have port chipselect, input, 1 bit: slave select.
REQ-009 SHALL have port read, input, 1 bit: read strobe.
REQ-010 SHALL have port write, input, 1 bit: write strobe.
REQ-011 SHALL have port writedata, input, 32 bits: write data.
REQ-012 SHALL have port readdata, output, 32 bits: registered read data.
REQ-013 SHALL have port readdatavalid, output, 1 bit: readdata qualifier.
REQ-014 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-015 Each in_export bit SHALL be XORed with INVERT_MASK, then passed through a 2-flop synchronizer.
REQ-016 Each channel SHALL have its own counter, width clog2(DEBOUNCE_CYCLES+1).
- The counter clears whenever the synchronized bit equals the stable bit.
- Otherwise it increments by 1 per cycle.
REQ-017 When the counter reaches DEBOUNCE_CYCLES-1 while the mismatch persists:
- the stable bit SHALL toggle on the next edge;
- the counter SHALL clear;
- total latency from raw change to stable change SHALL be 2 + DEBOUNCE_CYCLES cycles.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change the stable value.
REQ-019 A stable-bit transition SHALL set the matching edge_capture bit as follows:
- on a rising transition, if edge_mode[0]=1;
- on a falling transition, if edge_mode[1]=1.
REQ-020 Register map (word address: contents):
- 0: DATA. Read-only; the stable bits, zero-extended to 32 bits. Writes are ignored.
- 1: IRQ_MASK. Read/write, WIDTH bits.
- 2: EDGE_CAPTURE. Read returns the captured bits. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
- 3: EDGE_MODE. Read/write, bits [1:0]; bits [31:2] read as 0.
REQ-021 Reads, when chipselect & read, SHALL have a fixed 1-cycle latency:
- readdata and readdatavalid register on the next edge;
- readdatavalid SHALL be high for exactly one cycle per accepted read;
- readdata SHALL hold its value until the next accepted read.
REQ-022 Writes are accepted when chipselect & write and take effect on that clock edge. There are no wait states.
REQ-023 If a write-1-to-clear and a new edge hit the same EDGE_CAPTURE bit in the same cycle, the bit SHALL remain set (set wins).
REQ-024 If chipselect, read and write are all high together, the write SHALL take effect. The read SHALL return the pre-write value.
REQ-025 irq SHALL be registered and equal the OR over all bits of (EDGE_CAPTURE & IRQ_MASK). It asserts 1 cycle after the capture bit sets.
REQ-026 Unused upper bits of readdata SHALL read 0. writedata bits at or above WIDTH SHALL be ignored.

Reset
REQ-027 On reset_reset=1 at a clock edge, the following SHALL clear to 0 at that edge:
- synchronizers, counters and stable bits;
- IRQ_MASK and EDGE_CAPTURE;
- readdata, readdatavalid and irq.
REQ-028 On reset, EDGE_MODE SHALL be set to 2'b01 (rising edges only).
REQ-029 Reset mid-debounce SHALL discard the partial count. After reset is released, debouncing restarts from stable=0 with no spurious edge capture.
REQ-030 Reset SHALL override any simultaneous bus write.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, INVERT_MASK=4'b1000)
REQ-031 Drive in_export=4'b1001 and hold for 10 cycles:
- DATA changes from 0 to 0x1 exactly 6 cycles after the input change;
- bit 3 never sets (inverted high reads 0);
- EDGE_CAPTURE=0x1.
REQ-032 Pulse in_export[1] high for 3 cycles, then low:
- DATA bit 1 stays 0;
- EDGE_CAPTURE bit 1 stays 0.
REQ-033 IRQ_MASK=0x1, then trigger a rising edge on bit 0:
- irq rises 1 cycle after EDGE_CAPTURE[0] sets;
- writing 0x1 to address 2 clears the bit, and irq drops on the next cycle.
REQ-034 EDGE_MODE=2'b10:
- a rising edge on bit 2 does not capture;
- the following falling edge sets EDGE_CAPTURE[2].
REQ-035 Write 0x1 to address 2 in the same cycle bit 0 captures a new edge:
- EDGE_CAPTURE[0] reads 1.
REQ-036 Assert reset 2 cycles into a debounce count, release it, and hold the input:
- all outputs are 0 during reset;
- EDGE_MODE reads 0x1;
- DATA updates 6 cycles after release.

Source files
------------

// File: rtl/pio_debounce_capture.sv
// pio_debounce_capture: debounced parallel input port with per-channel
// edge capture and a level interrupt. Exposed as an Avalon-MM slave with
// no wait states and a fixed one-cycle read latency.
module pio_debounce_capture #(
   parameter int               WIDTH           = 18,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter logic [WIDTH-1:0] INVERT_MASK     = '0
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [WIDTH-1:0] in_export,
   input  logic [1:0]       address,
   input  logic             chipselect,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic             readdatavalid,
   output logic             irq
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      ADDR_DATA         = 2'd0,
      ADDR_IRQ_MASK     = 2'd1,
      ADDR_EDGE_CAPTURE = 2'd2,
      ADDR_EDGE_MODE    = 2'd3
   } reg_addr_e;

   // Input conditioning and debounce state
   logic [WIDTH-1:0] sync1_q;
   logic [WIDTH-1:0] sync2_q;
   logic [WIDTH-1:0] stable_q;
   logic [WIDTH-1:0] stable_d;
   logic [WIDTH-1:0] toggle;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];

   // Bus-visible registers
   logic [WIDTH-1:0] irq_mask_q;
   logic [WIDTH-1:0] irq_mask_d;
   logic [WIDTH-1:0] edge_cap_q;
   logic [WIDTH-1:0] edge_cap_d;
   logic [1:0]       edge_mode_q;
   logic [1:0]       edge_mode_d;
   logic [31:0]      readdata_q;
   logic [31:0]      readdata_d;
   logic             readdatavalid_q;
   logic             irq_q;
   logic             irq_d;

   // Bus decode helpers
   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] clr_mask;
   logic [WIDTH-1:0] edge_set;

   // Upper writedata bits beyond WIDTH are intentionally ignored.
   logic unused_writedata;
   assign unused_writedata = ^writedata;

   assign wr_en = chipselect & write;
   assign rd_en = chipselect & read;

   // Synchronize the (optionally inverted) raw inputs and advance debounce state.
   always_ff @(posedge clk_clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (reset_reset) begin
         sync1_q  <= '0;
         sync2_q  <= '0;
         stable_q <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         sync1_q  <= in_export ^ INVERT_MASK;
         sync2_q  <= sync1_q;
         stable_q <= stable_d;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   // Per-channel mismatch counter; the stable bit flips once the mismatch
   // has persisted for DEBOUNCE_CYCLES consecutive cycles.
   always_comb begin
      // NOTE: every output gets a default before any branch, so no path
      // leaves a signal unassigned and no latch is inferred.
      toggle = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               toggle[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
      stable_d = stable_q ^ toggle;
   end

   // Register-file next state, edge capture (set wins over clear) and read mux.
   always_comb begin
      irq_mask_d  = irq_mask_q;
      edge_mode_d = edge_mode_q;
      clr_mask    = '0;
      readdata_d  = readdata_q;

      if (wr_en) begin
         case (reg_addr_e'(address))
            ADDR_IRQ_MASK:     irq_mask_d  = writedata[WIDTH-1:0];
            ADDR_EDGE_CAPTURE: clr_mask    = writedata[WIDTH-1:0];
            ADDR_EDGE_MODE:    edge_mode_d = writedata[1:0];
            default:           ;
         endcase
      end

      edge_set   = (toggle & ~stable_q & {WIDTH{edge_mode_q[0]}})
                 | (toggle &  stable_q & {WIDTH{edge_mode_q[1]}});
      edge_cap_d = (edge_cap_q & ~clr_mask) | edge_set;

      // Reads see the pre-write register contents.
      if (rd_en) begin
         readdata_d = '0;
         case (reg_addr_e'(address))
            ADDR_DATA:         readdata_d[WIDTH-1:0] = stable_q;
            ADDR_IRQ_MASK:     readdata_d[WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAPTURE: readdata_d[WIDTH-1:0] = edge_cap_q;
            ADDR_EDGE_MODE:    readdata_d[1:0]       = edge_mode_q;
            default:           ;
         endcase
      end

      irq_d = |(edge_cap_q & irq_mask_q);
   end

   // Bus registers, read response and interrupt; reset overrides any write.
   always_ff @(posedge clk_clk) begin
      if (reset_reset) begin
         irq_mask_q      <= '0;
         edge_cap_q      <= '0;
         edge_mode_q     <= 2'b01;
         readdata_q      <= '0;
         readdatavalid_q <= 1'b0;
         irq_q           <= 1'b0;
      end else begin
         irq_mask_q      <= irq_mask_d;
         edge_cap_q      <= edge_cap_d;
         edge_mode_q     <= edge_mode_d;
         readdata_q      <= readdata_d;
         readdatavalid_q <= rd_en;
         irq_q           <= irq_d;
      end
   end

   assign readdata      = readdata_q;
   assign readdatavalid = readdatavalid_q;
   assign irq           = irq_q;

endmodule
